// File: rtl/ddc_pkg.sv
// Shared width/latency helpers and the stage-output reduction for the DDC chain.
// Build option DDC_SAT_EN: stage outputs saturate instead of wrapping.
package ddc_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int mix_width(input int w_in);
        return w_in + 2;
    endfunction

    function automatic int acc_width(input int w_mix, input int order, input int r_max);
        return w_mix + order * clog2(r_max);
    endfunction

    function automatic int sh_width(input int w_acc);
        return clog2(w_acc);
    endfunction

    function automatic int lat(input int order);
        return 2 + 2 * (2 * order + 1) + 1;
    endfunction

    // Result is meant to be sliced to its low w bits by the caller.
    function automatic logic signed [63:0] reduce(input logic signed [63:0] v, input int w);
`ifdef DDC_SAT_EN
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v > hi) return hi;
        if (v < -hi - 64'sd1) return -hi - 64'sd1;
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/cic_dec_stage.sv
// One CIC decimator: ORDER pipelined integrators, rate counter, ORDER combs, shift and reduction.
module cic_dec_stage
    import ddc_pkg::*;
#(
    parameter int W_I   = 18,
    parameter int W_O   = 18,
    parameter int ORDER = 5,
    parameter int R_MAX = 8,
    localparam int W_ACC = acc_width(W_I, ORDER, R_MAX),
    localparam int W_SH  = sh_width(W_ACC),
    localparam int W_R   = clog2(R_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic [W_R-1:0]        rate,
    input  logic [W_SH-1:0]       shift,
    input  logic                  in_valid,
    input  logic signed [W_I-1:0] in_data,
    output logic                  out_valid,
    output logic signed [W_O-1:0] out_data
);

    logic signed [W_ACC-1:0] integ_p0 [ORDER];
    logic [ORDER-1:0]        vld_p0;
    logic signed [W_ACC-1:0] dec_p1;
    logic                    vld_p1;
    logic [W_R-1:0]          cnt;
    logic [W_R-1:0]          rate_eff;
    logic signed [W_ACC-1:0] comb_p2 [ORDER];
    logic signed [W_ACC-1:0] dly_p2 [ORDER];
    logic [ORDER-1:0]        vld_p2;
    logic signed [W_ACC-1:0] shifted;

    always_comb begin
        rate_eff = rate;
        if (rate == '0) rate_eff = W_R'(1);
        else if (rate > W_R'(R_MAX)) rate_eff = W_R'(R_MAX);
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_p0[k] <= '0;
                comb_p2[k]  <= '0;
                dly_p2[k]   <= '0;
            end
            vld_p0 <= '0;
            dec_p1 <= '0;
            vld_p1 <= 1'b0;
            cnt    <= '0;
            vld_p2 <= '0;
        end else begin
            // integrator chain: each section runs one cycle behind the previous
            vld_p0 <= {vld_p0[ORDER-2:0], in_valid};
            if (in_valid) integ_p0[0] <= integ_p0[0] + W_ACC'(in_data);
            for (int k = 1; k < ORDER; k++)
                if (vld_p0[k-1]) integ_p0[k] <= integ_p0[k] + integ_p0[k-1];

            // decimator register
            vld_p1 <= 1'b0;
            if (vld_p0[ORDER-1]) begin
                if (cnt == rate_eff - W_R'(1)) begin
                    cnt    <= '0;
                    vld_p1 <= 1'b1;
                    dec_p1 <= integ_p0[ORDER-1];
                end else begin
                    cnt <= cnt + W_R'(1);
                end
            end

            // comb chain
            vld_p2 <= {vld_p2[ORDER-2:0], vld_p1};
            if (vld_p1) begin
                comb_p2[0] <= dec_p1 - dly_p2[0];
                dly_p2[0]  <= dec_p1;
            end
            for (int k = 1; k < ORDER; k++)
                if (vld_p2[k-1]) begin
                    comb_p2[k] <= comb_p2[k-1] - dly_p2[k];
                    dly_p2[k]  <= comb_p2[k-1];
                end
        end
    end

    always_comb begin
        shifted  = comb_p2[ORDER-1] >>> shift;
        out_data = W_O'(reduce(64'(shifted), W_O));
    end

    assign out_valid = vld_p2[ORDER-1];

endmodule

// File: rtl/ddc_cic_dec_prog.sv
// Single-clock DDC: complex mixer, two programmable CIC decimators (I/Q), output register.
// Build option DDC_SAT_EN selects saturating stage outputs (default: wrap).
module ddc_cic_dec_prog
    import ddc_pkg::*;
#(
    parameter int W_IN  = 16,
    parameter int W_OUT = 20,
    parameter int ORDER = 5,
    parameter int R_MAX = 8,
    localparam int W_MIX = mix_width(W_IN),
    localparam int W_ACC = acc_width(W_MIX, ORDER, R_MAX),
    localparam int W_SH  = sh_width(W_ACC),
    localparam int W_R   = clog2(R_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [W_IN-1:0]  lo_i,
    input  logic signed [W_IN-1:0]  lo_q,
    input  logic signed [W_IN-1:0]  sig_i,
    input  logic signed [W_IN-1:0]  sig_q,
    input  logic                    cfg_load,
    input  logic [W_R-1:0]          cfg_rate1,
    input  logic [W_R-1:0]          cfg_rate2,
    input  logic [W_SH-1:0]         cfg_shift1,
    input  logic [W_SH-1:0]         cfg_shift2,
    output logic                    out_valid,
    output logic signed [W_OUT-1:0] out_i,
    output logic signed [W_OUT-1:0] out_q
);

    localparam int W_PR = 2 * W_IN;
    localparam int W_PS = 2 * W_IN + 1;

    logic                    flush;
    logic [W_R-1:0]          rate1, rate2;
    logic [W_SH-1:0]         shift1, shift2;
    logic signed [W_PR-1:0]  p_ii_p0, p_qq_p0, p_iq_p0, p_qi_p0;
    logic                    vld_p0, vld_p1;
    logic signed [W_PS-1:0]  sum_i, sum_q;
    logic signed [W_MIX-1:0] mix_i_p1, mix_q_p1;
    logic                    s1_vld_i, s1_vld_q, s2_vld_i, s2_vld_q;
    logic signed [W_MIX-1:0] s1_i, s1_q;
    logic signed [W_OUT-1:0] s2_i, s2_q;

    assign flush = reset | cfg_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            rate1  <= W_R'(1);
            rate2  <= W_R'(1);
            shift1 <= '0;
            shift2 <= '0;
        end else if (cfg_load) begin
            rate1  <= cfg_rate1;
            rate2  <= cfg_rate2;
            shift1 <= cfg_shift1;
            shift2 <= cfg_shift2;
        end
    end

    always_comb begin
        sum_i = W_PS'(p_ii_p0) - W_PS'(p_qq_p0);
        sum_q = W_PS'(p_iq_p0) + W_PS'(p_qi_p0);
    end

    // mixer: products, then sum and rescale by the LO full-scale
    always_ff @(posedge clk) begin
        if (flush) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            p_ii_p0  <= '0;
            p_qq_p0  <= '0;
            p_iq_p0  <= '0;
            p_qi_p0  <= '0;
            mix_i_p1 <= '0;
            mix_q_p1 <= '0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                p_ii_p0 <= W_PR'(lo_i) * W_PR'(sig_i);
                p_qq_p0 <= W_PR'(lo_q) * W_PR'(sig_q);
                p_iq_p0 <= W_PR'(lo_i) * W_PR'(sig_q);
                p_qi_p0 <= W_PR'(lo_q) * W_PR'(sig_i);
            end
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                mix_i_p1 <= W_MIX'(sum_i >>> (W_IN - 1));
                mix_q_p1 <= W_MIX'(sum_q >>> (W_IN - 1));
            end
        end
    end

    cic_dec_stage #(.W_I(W_MIX), .W_O(W_MIX), .ORDER(ORDER), .R_MAX(R_MAX)) u_s1_i (
        .clk(clk), .flush(flush), .rate(rate1), .shift(shift1),
        .in_valid(vld_p1), .in_data(mix_i_p1), .out_valid(s1_vld_i), .out_data(s1_i)
    );
    cic_dec_stage #(.W_I(W_MIX), .W_O(W_MIX), .ORDER(ORDER), .R_MAX(R_MAX)) u_s1_q (
        .clk(clk), .flush(flush), .rate(rate1), .shift(shift1),
        .in_valid(vld_p1), .in_data(mix_q_p1), .out_valid(s1_vld_q), .out_data(s1_q)
    );
    cic_dec_stage #(.W_I(W_MIX), .W_O(W_OUT), .ORDER(ORDER), .R_MAX(R_MAX)) u_s2_i (
        .clk(clk), .flush(flush), .rate(rate2), .shift(shift2),
        .in_valid(s1_vld_i & s1_vld_q), .in_data(s1_i), .out_valid(s2_vld_i), .out_data(s2_i)
    );
    cic_dec_stage #(.W_I(W_MIX), .W_O(W_OUT), .ORDER(ORDER), .R_MAX(R_MAX)) u_s2_q (
        .clk(clk), .flush(flush), .rate(rate2), .shift(shift2),
        .in_valid(s1_vld_i & s1_vld_q), .in_data(s1_q), .out_valid(s2_vld_q), .out_data(s2_q)
    );

    // output register holds the last decimated sample
    always_ff @(posedge clk) begin
        if (flush) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            out_valid <= s2_vld_i & s2_vld_q;
            if (s2_vld_i & s2_vld_q) begin
                out_i <= s2_i;
                out_q <= s2_q;
            end
        end
    end

endmodule

// File: tb/tb_ddc_cic_dec_prog.sv
// Bench for ddc_cic_dec_prog: directed and random runs against a convolution-based CIC model.
module tb_ddc_cic_dec_prog;

    localparam int W_IN  = 16;
    localparam int W_OUT = 20;
    localparam int ORDER = 5;
    localparam int R_MAX = 8;
    localparam int W_MIX = W_IN + 2;
    localparam int W_SH  = 6;
    localparam int W_R   = 4;
    localparam int LAT   = 25;

    typedef longint lq_t[$];

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic signed [W_IN-1:0]  lo_i = '0, lo_q = '0, sig_i = '0, sig_q = '0;
    logic                    cfg_load = 1'b0;
    logic [W_R-1:0]          cfg_rate1 = W_R'(1), cfg_rate2 = W_R'(1);
    logic [W_SH-1:0]         cfg_shift1 = '0, cfg_shift2 = '0;
    logic                    out_valid;
    logic signed [W_OUT-1:0] out_i, out_q;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint load_edge = 0;
    lq_t    in_edge, xi, xq, out_edge, oi, oq;
    int     cur_r1, cur_r2, cur_s1, cur_s2;

    ddc_cic_dec_prog dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .lo_i(lo_i), .lo_q(lo_q), .sig_i(sig_i), .sig_q(sig_q),
        .cfg_load(cfg_load), .cfg_rate1(cfg_rate1), .cfg_rate2(cfg_rate2),
        .cfg_shift1(cfg_shift1), .cfg_shift2(cfg_shift2),
        .out_valid(out_valid), .out_i(out_i), .out_q(out_q)
    );

    always #5 clk = ~clk;

    // Accepted inputs: edge index and ideal complex product rescaled by 2^(W_IN-1).
    always @(posedge clk) begin
        if (!reset && !cfg_load && in_valid) begin
            in_edge.push_back(cyc);
            xi.push_back((longint'(lo_i) * longint'(sig_i) - longint'(lo_q) * longint'(sig_q)) >>> (W_IN - 1));
            xq.push_back((longint'(lo_i) * longint'(sig_q) + longint'(lo_q) * longint'(sig_i)) >>> (W_IN - 1));
        end
        cyc++;
    end

    // Output pulses, tagged with the edge that registered them.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_edge.push_back(cyc - 1);
            oi.push_back(longint'(out_i));
            oq.push_back(longint'(out_q));
        end
    end

    function automatic int clamp_r(input int r);
        if (r == 0) return 1;
        if (r > R_MAX) return R_MAX;
        return r;
    endfunction

    function automatic longint reduce_ref(input longint v, input int w);
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
`ifdef DDC_SAT_EN
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
`else
        v = v & ((hi << 1) + 1);
        if (v > hi) v = v - ((hi << 1) + 2);
        return v;
`endif
    endfunction

    // CIC = input convolved with ORDER boxcars of length R, sampled every R-th input.
    function automatic void cic_model(input lq_t x, input int r_raw, input int sh, input int w, output lq_t y);
        lq_t    h, t;
        int     r;
        longint acc;
        r = clamp_r(r_raw);
        h = {};
        h.push_back(1);
        y = {};
        for (int s = 0; s < ORDER; s++) begin
            t = {};
            for (int i = 0; i < h.size() + r - 1; i++) begin
                acc = 0;
                for (int j = 0; j < r; j++)
                    if (i - j >= 0 && i - j < h.size()) acc += h[i - j];
                t.push_back(acc);
            end
            h = t;
        end
        for (int m = 0; m < x.size() / r; m++) begin
            acc = 0;
            for (int j = 0; j < h.size() && j <= m * r + r - 1; j++)
                acc += h[j] * x[m * r + r - 1 - j];
            y.push_back(reduce_ref(acc >>> sh, w));
        end
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // cfg_load pulse with in_valid high in the same cycle (that sample must be dropped).
    task automatic load(input int r1, input int r2, input int s1, input int s2);
        @(negedge clk);
        cfg_load   = 1'b1;
        in_valid   = 1'b1;
        cfg_rate1  = W_R'(r1);
        cfg_rate2  = W_R'(r2);
        cfg_shift1 = W_SH'(s1);
        cfg_shift2 = W_SH'(s2);
        cur_r1 = r1; cur_r2 = r2; cur_s1 = s1; cur_s2 = s2;
        @(negedge clk);
        cfg_load  = 1'b0;
        in_valid  = 1'b0;
        load_edge = cyc - 1;
        in_edge = {}; xi = {}; xq = {};
        out_edge = {}; oi = {}; oq = {};
    endtask

    // gap = 0: random gaps; rnd = 1: random LO/signal per cycle.
    task automatic drive(input int n, input int gap, input bit rnd);
        int sent, phase;
        bit v;
        sent = 0;
        phase = 0;
        while (sent < n) begin
            @(negedge clk);
            if (gap == 0) v = ($urandom_range(0, 2) != 0);
            else v = (phase % gap == 0);
            phase++;
            if (rnd) begin
                lo_i = W_IN'($urandom); lo_q = W_IN'($urandom);
                sig_i = W_IN'($urandom); sig_q = W_IN'($urandom);
            end
            in_valid = v;
            if (v) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Compare every pulse already due against the model: value and timing.
    task automatic check_run(input string name);
        lq_t y1i, y1q, y2i, y2q;
        int  d, n_exp, n;
        cic_model(xi, cur_r1, cur_s1, W_MIX, y1i);
        cic_model(xq, cur_r1, cur_s1, W_MIX, y1q);
        cic_model(y1i, cur_r2, cur_s2, W_OUT, y2i);
        cic_model(y1q, cur_r2, cur_s2, W_OUT, y2q);
        d = clamp_r(cur_r1) * clamp_r(cur_r2);
        n_exp = 0;
        // out_valid is registered on the LAT-th edge counting the completing input's own edge
        while (n_exp < y2i.size() && in_edge[(n_exp + 1) * d - 1] + LAT - 1 <= cyc - 1) n_exp++;
        chk({name, "_count"}, out_edge.size(), n_exp);
        n = (out_edge.size() < n_exp) ? out_edge.size() : n_exp;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_edge[%0d]", name, k), out_edge[k], in_edge[(k + 1) * d - 1] + LAT - 1);
            chk($sformatf("%s_i[%0d]", name, k), oi[k], y2i[k]);
            chk($sformatf("%s_q[%0d]", name, k), oq[k], y2q[k]);
        end
    endtask

    initial begin
        int r1, r2;
        // reset held 3 cycles with in_valid high, then quiet for LAT cycles
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", out_valid, 0);
            chk("rst_i", out_i, 0);
            chk("rst_q", out_q, 0);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (LAT) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_i", out_i, 0);
        end

        // DC gain, continuous input
        lo_i = 16'sh4000; lo_q = '0; sig_i = 16'sh2000; sig_q = '0;
        load(4, 2, 10, 5);
        drive(160, 1, 1'b0);
        idle(40);
        check_run("dc");
        chk("dc_first_lat", out_edge[0] - in_edge[7], LAT - 1);
        chk("dc_spacing", out_edge[$] - out_edge[$-1], 8);
        chk("dc_settled_i", oi[$], 4096);
        chk("dc_settled_q", oq[$], 0);
        chk("dc_hold_i", out_i, 4096);

        // gapped input, one sample every third cycle
        load(4, 2, 10, 5);
        drive(128, 3, 1'b0);
        idle(40);
        check_run("gap");
        chk("gap_spacing", out_edge[$] - out_edge[$-1], 24);
        chk("gap_settled_i", oi[$], 4096);

        // stage-1 overflow: 4096 * 4^5 does not fit W_MIX
        load(4, 2, 0, 5);
        drive(160, 1, 1'b0);
        idle(40);
        check_run("sat");
`ifdef DDC_SAT_EN
        chk("sat_settled_i", oi[$], 131071);
`else
        chk("sat_settled_i", oi[$], 0);
`endif

        // mixer corners at unity rate
        lo_i = -16'sd32768; lo_q = -16'sd32768; sig_i = -16'sd32768; sig_q = -16'sd32768;
        load(1, 1, 0, 0);
        drive(20, 1, 1'b0);
        idle(40);
        check_run("corner");
        chk("corner_i", oi[$], 0);
        chk("corner_q", oq[$], 65536);

        // random data, rates (incl. 0 and above R_MAX) and gaps
        for (int it = 0; it < 3; it++) begin
            r1 = (it == 0) ? 0 : $urandom_range(1, R_MAX);
            r2 = (it == 0) ? 11 : $urandom_range(1, R_MAX);
            load(r1, r2, $urandom_range(0, 15), $urandom_range(0, 15));
            drive(clamp_r(r1) * clamp_r(r2) * 8, 0, 1'b1);
            idle(40);
            check_run($sformatf("rand%0d", it));
        end

        // cfg_load while the pipeline is still busy
        lo_i = 16'sh4000; lo_q = '0; sig_i = 16'sh2000; sig_q = '0;
        load(4, 2, 10, 5);
        drive(64, 1, 1'b0);
        idle(5);
        check_run("preload");
        load(5, 1, 0, 0);
        drive(50, 1, 1'b0);
        idle(40);
        check_run("midrun");
        chk("midrun_quiet", (out_edge.size() > 0) && (out_edge[0] - load_edge > LAT), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
